servo_ramp_pwm: RTL and testbench

Single-axis servo drive stage sitting directly downstream of the clock divider in the automated-motion path. Consumes the divider's slow square wave as a step-rate reference, ramps the commanded servo position one step per slow-clock rising edge toward a target accepted over a valid/ready handshake, and emits a 50 Hz hobby-servo PWM whose pulse width tracks the ramped position. One instance per arm joint; the waypoint sequencer drives the target port.

---
 rtl/servo_pkg.sv | 50 +++++
 rtl/servo_pwm_gen.sv | 61 ++++++
 rtl/servo_ramp_pwm.sv | 118 +++++++++++
 tb/tb_servo_ramp_pwm.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared definitions for the servo ramp/PWM drive stage: state encoding,
// datapath widths, default timing constants and small arithmetic helpers.
package servo_pkg;

    localparam int POS_W = 8;
    localparam int CNT_W = 21;

    // Defaults for a 100 MHz system clock and a 50 Hz hobby-servo frame.
    localparam int unsigned DEF_PERIOD     = 2000000;
    localparam int unsigned DEF_MIN_PULSE  = 100000;
    localparam int unsigned DEF_PULSE_STEP = 392;
    localparam int unsigned DEF_HOME       = 128;
    localparam int unsigned DEF_RAMP_STEP  = 1;

    typedef logic [POS_W-1:0] pos_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_e;

    // Move cur toward tgt by at most step. Lands exactly on tgt when the
    // remaining distance is within one step, so the ramp never overshoots.
    // The 9-bit intermediate keeps cur+step from wrapping past 255.
    function automatic pos_t step_toward(pos_t cur, pos_t tgt, pos_t step);
        logic [POS_W:0] c9;
        logic [POS_W:0] t9;
        logic [POS_W:0] s9;
        logic [POS_W:0] r9;
        c9 = {1'b0, cur};
        t9 = {1'b0, tgt};
        s9 = {1'b0, step};
        if (t9 >= c9) begin
            r9 = ((t9 - c9) <= s9) ? t9 : (c9 + s9);
        end else begin
            r9 = ((c9 - t9) <= s9) ? t9 : (c9 - s9);
        end
        if (r9[POS_W]) begin
            r9 = {1'b0, {POS_W{1'b1}}};
        end
        return r9[POS_W-1:0];
    endfunction

    // Pulse width in clock cycles for a given position.
    function automatic cnt_t pulse_width(pos_t p, cnt_t min_pulse, cnt_t pulse_step);
        return min_pulse + (cnt_t'(p) * pulse_step);
    endfunction

endpackage

// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: free-running frame counter, per-frame width latch and
// registered compare. The width is only reloaded at the last count of a frame
// so a position change never alters a pulse already in flight.
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int unsigned PERIOD     = DEF_PERIOD,
    parameter int unsigned MIN_PULSE  = DEF_MIN_PULSE,
    parameter int unsigned PULSE_STEP = DEF_PULSE_STEP,
    parameter int unsigned HOME       = DEF_HOME
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [POS_W-1:0] pos_i,
    output logic             pwm_o
);

    localparam cnt_t LAST_CNT = cnt_t'(PERIOD - 1);
    localparam cnt_t HOME_W   = pulse_width(pos_t'(HOME), cnt_t'(MIN_PULSE), cnt_t'(PULSE_STEP));

    // The widest pulse must end before the frame does, and the frame must fit the counter.
    if ((longint'(MIN_PULSE) + 255 * longint'(PULSE_STEP) >= longint'(PERIOD)) ||
        (longint'(PERIOD) > (longint'(1) << CNT_W))) begin : g_bad_timing
        $error("servo_pwm_gen: maximum pulse width must be below PERIOD, PERIOD must fit the counter");
    end

    cnt_t cnt_q;
    cnt_t cnt_d;
    cnt_t width_q;
    cnt_t width_d;
    logic pwm_q;
    logic pwm_d;

    // Next-state for counter wrap, frame-boundary width reload and compare.
    always_comb begin
        // NOTE: every variable gets a default first so no path can leave one unassigned and infer a latch.
        cnt_d   = cnt_q + cnt_t'(1);
        width_d = width_q;
        pwm_d   = (cnt_q < width_q);
        if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            width_d = pulse_width(pos_i, cnt_t'(MIN_PULSE), cnt_t'(PULSE_STEP));
        end
    end

    // Frame state registers; reset parks at the start of a home-width frame with the output low.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            width_q <= HOME_W;
            pwm_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            width_q <= width_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/servo_ramp_pwm.sv
// Single-axis servo drive stage: synchronises the divided step clock into a
// one-cycle tick, ramps the commanded position toward a handshaked target
// one step per tick, and drives a hobby-servo PWM from the ramped position.
module servo_ramp_pwm
    import servo_pkg::*;
#(
    parameter int unsigned PERIOD     = DEF_PERIOD,
    parameter int unsigned MIN_PULSE  = DEF_MIN_PULSE,
    parameter int unsigned PULSE_STEP = DEF_PULSE_STEP,
    parameter int unsigned HOME       = DEF_HOME,
    parameter int unsigned RAMP_STEP  = DEF_RAMP_STEP
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             step_clk,
    input  logic             target_valid,
    input  logic [POS_W-1:0] target_pos,
    output logic             target_ready,
    output logic [POS_W-1:0] pos,
    output logic             busy,
    output logic             pwm
);

    // A zero step would never reach the target; a step above 255 is meaningless.
    if ((RAMP_STEP == 0) || (RAMP_STEP > 255) || (HOME > 255)) begin : g_bad_ramp
        $error("servo_ramp_pwm: RAMP_STEP must be 1..255 and HOME 0..255");
    end

    localparam pos_t HOME_POS = pos_t'(HOME);
    localparam pos_t STEP_POS = pos_t'(RAMP_STEP);

    logic   sync1_q;
    logic   sync2_q;
    logic   hist_q;
    logic   tick;
    state_e state_q;
    pos_t   pos_q;
    pos_t   target_q;
    pos_t   ramp_pos;
    logic   ready_q;
    logic   busy_q;

    // Two-flop synchronizer plus history flop for rising-edge detection of step_clk.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments make each flop capture its pre-edge input; blocking ones would collapse the chain into a single stage.
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= step_clk;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign tick     = sync2_q & ~hist_q;
    assign ramp_pos = step_toward(pos_q, target_q, STEP_POS);

    // Ramp FSM with registered handshake/status outputs. A tick coinciding
    // with an acceptance is ignored because IDLE never moves the position.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            pos_q    <= HOME_POS;
            target_q <= HOME_POS;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    if (target_valid && ready_q) begin
                        target_q <= target_pos;
                        if (target_pos != pos_q) begin
                            state_q <= RAMP;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RAMP: begin
                    if (tick) begin
                        pos_q <= ramp_pos;
                        if (ramp_pos == target_q) begin
                            state_q <= IDLE;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    servo_pwm_gen #(
        .PERIOD    (PERIOD),
        .MIN_PULSE (MIN_PULSE),
        .PULSE_STEP(PULSE_STEP),
        .HOME      (HOME)
    ) u_pwm_gen (
        .clock  (clock),
        .reset_n(reset_n),
        .pos_i  (pos_q),
        .pwm_o  (pwm)
    );

    assign target_ready = ready_q;
    assign pos          = pos_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_servo_ramp_pwm.sv
// Self-checking bench for servo_ramp_pwm. Expected positions and pulse widths
// are pushed to queues when stimulus is driven; monitors pop and compare them
// as the design produces position changes and PWM pulses.
module tb_servo_ramp_pwm;

    localparam int unsigned PERIOD     = 1000;
    localparam int unsigned MIN_PULSE  = 50;
    localparam int unsigned PULSE_STEP = 1;
    localparam int unsigned HOME       = 128;

    logic       clock    = 1'b0;
    logic       reset_n  = 1'b0;
    logic       step_clk = 1'b0;

    logic       tv1 = 1'b0;
    logic [7:0] tp1 = 8'd0;
    logic       tr1;
    logic [7:0] pos1;
    logic       busy1;
    logic       pwm1;

    logic       tv3 = 1'b0;
    logic [7:0] tp3 = 8'd0;
    logic       tr3;
    logic [7:0] pos3;
    logic       busy3;
    logic       pwm3;

    servo_ramp_pwm #(
        .PERIOD(PERIOD), .MIN_PULSE(MIN_PULSE), .PULSE_STEP(PULSE_STEP),
        .HOME(HOME), .RAMP_STEP(1)
    ) u_dut (
        .clock(clock), .reset_n(reset_n), .step_clk(step_clk),
        .target_valid(tv1), .target_pos(tp1), .target_ready(tr1),
        .pos(pos1), .busy(busy1), .pwm(pwm1)
    );

    servo_ramp_pwm #(
        .PERIOD(PERIOD), .MIN_PULSE(MIN_PULSE), .PULSE_STEP(PULSE_STEP),
        .HOME(HOME), .RAMP_STEP(3)
    ) u_dut3 (
        .clock(clock), .reset_n(reset_n), .step_clk(step_clk),
        .target_valid(tv3), .target_pos(tp3), .target_ready(tr3),
        .pos(pos3), .busy(busy3), .pwm(pwm3)
    );

    always #5 clock = ~clock;

    // Step clock: period 20 system clocks, edges placed just after a rising clock edge.
    initial begin
        forever begin
            repeat (10) @(posedge clock);
            #1 step_clk = ~step_clk;
        end
    end

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         rise_cyc = -100;
    logic [7:0] exp_q[$];
    int         pw_exp_q[$];
    logic [7:0] mpos1 = 8'd128;
    int         chg3  = 0;
    logic       wrap3 = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Position scoreboard for the RAMP_STEP=1 instance, plus step-to-move latency.
    initial begin : mon_pos1
        logic step_prev;
        logic [7:0] prev;
        step_prev = 1'b0;
        prev = 8'd0;
        forever begin
            @(negedge clock);
            cyc++;
            if (step_clk && !step_prev) rise_cyc = cyc;
            step_prev = step_clk;
            if (!reset_n) begin
                prev = pos1;
            end else if (pos1 !== prev) begin
                if (exp_q.size() > 0) check("pos_value", pos1, exp_q.pop_front());
                else check("pos_unexpected_move", pos1, prev);
                check("pos_latency", cyc - rise_cyc, 3);
                prev = pos1;
            end
        end
    end

    // Pulse-width scoreboard: each completed pulse is compared with the next expectation.
    initial begin : mon_pwm1
        int len;
        logic in_p;
        len = 0;
        in_p = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                in_p = 1'b0;
                len = 0;
            end else if (pwm1) begin
                in_p = 1'b1;
                len++;
            end else if (in_p) begin
                if (pw_exp_q.size() > 0) check("pwm_width", len, pw_exp_q.pop_front());
                in_p = 1'b0;
                len = 0;
            end
        end
    end

    // Move counter and wrap detector for the RAMP_STEP=3 instance.
    initial begin : mon_pos3
        logic [7:0] prev;
        prev = 8'd0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                prev = pos3;
            end else if (pos3 !== prev) begin
                chg3++;
                if (pos3 == 8'd255) wrap3 = 1'b1;
                prev = pos3;
            end
        end
    end

    // Reference ramp: push every intermediate position from mpos1 to tgt.
    task automatic push_ramp1(input logic [7:0] tgt);
        int m;
        m = mpos1;
        while (m != tgt) begin
            if (tgt > m) m = (tgt - m <= 1) ? tgt : m + 1;
            else m = (m - tgt <= 1) ? tgt : m - 1;
            exp_q.push_back(8'(m));
        end
        mpos1 = tgt;
    endtask

    task automatic send1(input logic [7:0] val);
        int n;
        n = 0;
        while (tr1 !== 1'b1 && n < 500) begin
            @(negedge clock);
            n++;
        end
        check("ready_before_send", tr1, 1);
        tv1 = 1'b1;
        tp1 = val;
        push_ramp1(val);
        @(negedge clock);
        tv1 = 1'b0;
        check("busy_after_accept", busy1, 1);
        check("ready_low_after_accept", tr1, 0);
    endtask

    task automatic wait_idle1();
        int n;
        n = 0;
        @(negedge clock);
        while (busy1 !== 1'b0 && n < 2500) begin
            @(negedge clock);
            n++;
        end
        check("busy_cleared", busy1, 0);
        check("ready_at_done", tr1, 1);
        check("pos_at_target", pos1, mpos1);
        @(negedge clock);
        check("pos_sb_drained", exp_q.size(), 0);
    endtask

    task automatic send3(input logic [7:0] val);
        int n;
        n = 0;
        while (tr3 !== 1'b1 && n < 500) begin
            @(negedge clock);
            n++;
        end
        check("ready3_before_send", tr3, 1);
        tv3 = 1'b1;
        tp3 = val;
        @(negedge clock);
        tv3 = 1'b0;
        check("busy3_after_accept", busy3, 1);
    endtask

    task automatic wait_idle3();
        int n;
        n = 0;
        while (busy3 !== 1'b0 && n < 2500) begin
            @(negedge clock);
            n++;
        end
        check("busy3_cleared", busy3, 0);
    endtask

    task automatic wait_pwm_rise();
        int n;
        logic prev;
        logic seen;
        n = 0;
        seen = 1'b0;
        @(negedge clock);
        prev = pwm1;
        while (!seen && n < 2 * PERIOD) begin
            @(negedge clock);
            if (pwm1 && !prev) seen = 1'b1;
            prev = pwm1;
            n++;
        end
        check("pwm_rise_seen", seen, 1);
    endtask

    initial begin : driver
        int hi;
        int n;

        // Reset state.
        repeat (3) @(negedge clock);
        check("rst_pos", pos1, 128);
        check("rst_ready", tr1, 0);
        check("rst_busy", busy1, 0);
        check("rst_pwm", pwm1, 0);

        // Release: ready and pwm both high on the first cycle after.
        pw_exp_q.push_back(178);
        pw_exp_q.push_back(178);
        reset_n = 1'b1;
        @(negedge clock);
        check("ready_first_cycle", tr1, 1);
        check("pwm_first_cycle", pwm1, 1);
        hi = int'(pwm1);
        for (int i = 1; i < PERIOD; i++) begin
            @(negedge clock);
            hi += int'(pwm1);
        end
        check("frame_high_count", hi, 178);
        check("idle_pos", pos1, 128);

        // Ramp up by three single steps.
        send1(8'd131);
        wait_idle1();

        // Target held during a ramp is only taken once ready rises, in that same cycle.
        send1(8'd140);
        tv1 = 1'b1;
        tp1 = 8'd200;
        n = 0;
        while (tr1 !== 1'b1 && n < 500) begin
            @(negedge clock);
            n++;
        end
        check("ready_rose", tr1, 1);
        check("busy_low_at_ready", busy1, 0);
        check("pos_before_retarget", pos1, 140);
        push_ramp1(8'd200);
        @(negedge clock);
        check("busy_held_accept", busy1, 1);
        tv1 = 1'b0;
        check("pos_sb_first_leg", exp_q.size() <= 60, 1);
        wait_idle1();

        // Position change inside a pulse: this frame keeps the old width.
        wait_pwm_rise();
        pw_exp_q.delete();
        pw_exp_q.push_back(250);
        pw_exp_q.push_back(247);
        send1(8'd197);
        wait_idle1();
        n = 0;
        while (pw_exp_q.size() > 0 && n < 3 * PERIOD) begin
            @(negedge clock);
            n++;
        end
        check("pwm_sb_drained", pw_exp_q.size(), 0);

        // RAMP_STEP=3: 128 -> 2, then 2 -> 0 in a single tick without wrap.
        send3(8'd2);
        wait_idle3();
        check("pos3_at_2", pos3, 2);
        chg3 = 0;
        send3(8'd0);
        wait_idle3();
        @(negedge clock);
        check("pos3_at_0", pos3, 0);
        check("pos3_one_move", chg3, 1);
        check("pos3_no_wrap", wrap3, 0);

        // Reset mid-ramp during a pulse.
        send1(8'd100);
        wait_pwm_rise();
        repeat (5) @(negedge clock);
        check("pre_rst_pwm", pwm1, 1);
        check("pre_rst_busy", busy1, 1);
        reset_n = 1'b0;
        exp_q.delete();
        pw_exp_q.delete();
        @(negedge clock);
        check("mid_rst_pwm", pwm1, 0);
        check("mid_rst_pos", pos1, 128);
        check("mid_rst_busy", busy1, 0);
        check("mid_rst_ready", tr1, 0);
        check("mid_rst_pos3", pos3, 128);
        mpos1 = 8'd128;
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_ready", tr1, 1);
        check("post_rst_pwm", pwm1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
